// File: rtl/hall98_sequencer.sv
// Program sequencer for the hall98 core: buffers (opcode, re, n) triples and issues
// them with opcode-specific hold times. Optional replay mode: HALL98_SEQ_REPEAT_EN.
module hall98_sequencer #(
    parameter int DEPTH   = 16,
    parameter int RE_W    = 4,
    parameter int N_W     = 32,
    parameter int ALU_CYC = 2,
    parameter int MUL_CYC = 4,
    parameter int MEM_CYC = 3
) (
    input  logic            iclock,
    input  logic            ireset_n,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [31:0]     load_op,
    input  logic [RE_W-1:0] load_re,
    input  logic [N_W-1:0]  load_n,
    input  logic            start,
    input  logic            abort,
`ifdef HALL98_SEQ_REPEAT_EN
    input  logic [3:0]      iters,
`endif
    output logic [31:0]     opcode,
    output logic [RE_W-1:0] re,
    output logic [N_W-1:0]  n,
    output logic            flag,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [7:0]      issue_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_END} state_t;
    state_t state, state_nx;

    logic [31:0]     mem_op [DEPTH];
    logic [RE_W-1:0] mem_re [DEPTH];
    logic [N_W-1:0]  mem_n  [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, head_idx;
    logic [AW:0]     count;
    logic            push, pop, clr;

    logic [31:0]     op_r;
    logic [RE_W-1:0] re_r;
    logic [N_W-1:0]  n_r;
    logic [15:0]     hold_cnt;
    logic [15:0]     lat;
    logic            legal, issue_more, hold_more;

    // Zero latency marks an illegal opcode.
    function automatic logic [15:0] op_lat(input logic [31:0] op);
        case (op)
            32'h45, 32'h46, 32'h47: op_lat = 16'(ALU_CYC);
            32'h48:                 op_lat = 16'(MUL_CYC);
            32'h49, 32'h4A:         op_lat = 16'(MEM_CYC);
            default:                op_lat = 16'd0;
        endcase
    endfunction

`ifdef HALL98_SEQ_REPEAT_EN
    logic [AW:0] run_len, run_idx;
    logic [3:0]  iter_idx, iter_tgt;
    logic        last_r;

    // Entries stay in place; a walking offset from the head replays the program.
    assign head_idx   = rd_ptr + run_idx[AW-1:0];
    assign issue_more = !((run_idx == run_len - 1'b1) && (iter_idx == iter_tgt - 4'd1));
    assign hold_more  = !last_r;
    assign pop        = 1'b0;
    assign clr        = (state == S_END);
    assign load_ready = (count != (AW+1)'(DEPTH)) && (state == S_IDLE);
`else
    assign head_idx   = rd_ptr;
    assign issue_more = (count > (AW+1)'(1));
    assign hold_more  = (count != '0);
    assign pop        = (state == S_ISSUE);
    assign clr        = 1'b0;
    assign load_ready = (count != (AW+1)'(DEPTH));
`endif

    assign push  = load_valid && load_ready;
    assign lat   = op_lat(mem_op[head_idx]);
    assign legal = (lat != 16'd0);

    always_ff @(posedge iclock) begin
        if (push) begin
            mem_op[wr_ptr] <= load_op;
            mem_re[wr_ptr] <= load_re;
            mem_n[wr_ptr]  <= load_n;
        end
    end

    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start && count != '0) state_nx = S_ISSUE;
            S_ISSUE: begin
                if (legal && lat > 16'd1) state_nx = S_HOLD;
                else                      state_nx = issue_more ? S_ISSUE : S_END;
            end
            S_HOLD:  if (hold_cnt == 16'd1) state_nx = hold_more ? S_ISSUE : S_END;
            S_END:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            state     <= S_IDLE;
            op_r      <= '0;
            re_r      <= '0;
            n_r       <= '0;
            hold_cnt  <= '0;
            err       <= 1'b0;
            issue_cnt <= '0;
`ifdef HALL98_SEQ_REPEAT_EN
            run_len   <= '0;
            run_idx   <= '0;
            iter_idx  <= '0;
            iter_tgt  <= '0;
            last_r    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (!abort) begin
                case (state)
                    S_IDLE: if (start) begin
                        if (count != '0) begin
                            err       <= 1'b0;
                            issue_cnt <= '0;
`ifdef HALL98_SEQ_REPEAT_EN
                            run_len   <= count;
                            run_idx   <= '0;
                            iter_idx  <= '0;
                            iter_tgt  <= (iters == 4'd0) ? 4'd1 : iters;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        if (legal) begin
                            op_r      <= mem_op[head_idx];
                            re_r      <= mem_re[head_idx];
                            n_r       <= mem_n[head_idx];
                            hold_cnt  <= lat - 16'd1;
                            issue_cnt <= issue_cnt + 8'd1;
                        end else begin
                            err <= 1'b1;
                        end
`ifdef HALL98_SEQ_REPEAT_EN
                        last_r <= !issue_more;
                        if (run_idx == run_len - 1'b1) begin
                            run_idx  <= '0;
                            iter_idx <= iter_idx + 4'd1;
                        end else begin
                            run_idx <= run_idx + 1'b1;
                        end
`endif
                    end
                    S_HOLD:  hold_cnt <= hold_cnt - 16'd1;
                    default: ;
                endcase
            end
        end
    end

    // Outputs decode from state so an asynchronous reset clears them immediately.
    always_comb begin
        opcode = '0;
        re     = '0;
        n      = '0;
        if (state == S_ISSUE && legal) begin
            opcode = mem_op[head_idx];
            re     = mem_re[head_idx];
            n      = mem_n[head_idx];
        end else if (state == S_HOLD) begin
            opcode = op_r;
            re     = re_r;
            n      = n_r;
        end
    end

    assign flag = (state == S_END);
    assign done = (state == S_END);
    assign busy = (state != S_IDLE);

endmodule

// File: doc/hall98_sequencer.md
Name: hall98_sequencer

Overview:
- Program sequencer in front of the hall98 core: buffers (opcode, re, n) instruction triples from a host, then drives the core's opcode/re/n inputs one instruction at a time.
- Holds each instruction stable for its opcode-specific latency; pulses flag when the program ends.
- Replaces hand-timed stimulus with a cycle-exact issue schedule.
- Sits between the host/loader and the hall98 core.

Parameters:
- DEPTH, 16, program buffer entries (power of 2, at least 2)
- RE_W, 4, register index width
- N_W, 32, immediate width
- ALU_CYC, 2, hold cycles for MOV/ADD/SUB (at least 1)
- MUL_CYC, 4, hold cycles for MUL (at least 1)
- MEM_CYC, 3, hold cycles for LDR/STR (at least 1)

Ports:
- iclock  in  1  clock; all state changes on its rising edge
- ireset_n  in  1  asynchronous active-low reset
- load_valid  in  1  host presents an instruction
- load_ready  out  1  buffer can accept; push happens when load_valid & load_ready
- load_op  in  32  instruction opcode
- load_re  in  RE_W  register index
- load_n  in  N_W  immediate/address
- start  in  1  begin execution (sampled in IDLE only)
- abort  in  1  synchronous: flush buffer, return to IDLE
- opcode  out  32  to core
- re  out  RE_W  to core
- n  out  N_W  to core
- flag  out  1  to core; 1-cycle end-of-program pulse
- busy  out  1  high in any state except IDLE
- done  out  1  1-cycle pulse, coincident with flag
- err  out  1  sticky: an illegal opcode was skipped; cleared on start
- issue_cnt  out  8  legal instructions issued since start; wraps 255 to 0

Behaviour:
- Reset (async, ireset_n=0): buffer empty, state IDLE, all outputs 0 except load_ready=1. Reset mid-run drops everything immediately; no flag is produced.
- Legal opcodes and hold lengths:
  - 0x45 MOV, 0x46 ADD, 0x47 SUB: ALU_CYC
  - 0x48 MUL: MUL_CYC
  - 0x49 LDR, 0x4A STR: MEM_CYC
  - Any other opcode is illegal.
- Buffer:
  - FIFO of DEPTH triples.
  - load_ready = !full, computed from the registered count. A push at full is refused even if a pop occurs in the same cycle.
  - Pushes are accepted in every state, including during a run.
  - A simultaneous push and pop leaves count unchanged.
- States: IDLE, ISSUE, HOLD, END.
  - IDLE:
    - opcode/re/n = 0.
    - start=1 with buffer non-empty: clear err and issue_cnt, go to ISSUE.
    - start=1 with buffer empty: set err, stay in IDLE.
  - ISSUE (one cycle):
    - Pop the head entry.
    - Legal opcode: drive opcode/re/n from the entry, load hold counter with (latency-1), increment issue_cnt, go to HOLD if latency>1, otherwise take the HOLD exit decision immediately.
    - Illegal opcode: outputs stay 0 for this cycle, set err, no issue_cnt increment, take the HOLD exit decision.
  - HOLD:
    - opcode/re/n held stable; counter decrements each cycle.
    - At 0: go to ISSUE if the buffer is non-empty (registered count), else go to END.
    - A push in that same cycle is not seen, so the program ends.
  - END (one cycle): opcode/re/n = 0; flag=1, done=1; go to IDLE.
- Timing:
  - First opcode appears on the cycle after start is sampled.
  - Back-to-back instructions have no NOP gap: the next opcode replaces the previous one on the cycle after its final hold cycle.
- abort:
  - Highest priority in any state except reset.
  - Next cycle: buffer empty, IDLE, outputs 0, no flag or done.
  - err and issue_cnt retain their values.
- busy = (state != IDLE).

Optional Feature:
- Macro: HALL98_SEQ_REPEAT_EN.
- When defined:
  - Adds input iters [3:0], sampled at start; 0 is treated as 1.
  - Entries are not popped at ISSUE; a read pointer walks the entries present at start.
  - After the last entry, the pointer rewinds to the first and the program replays until it has run iters times.
  - Then the buffer is cleared, END occurs, and flag pulses once.
  - Pushes during a run are refused (load_ready=0 while busy).
- When undefined: no iters port; single pass, entries consumed.

Test Plan:
- Reset: hold ireset_n=0 mid-HOLD of MUL -> opcode=0, busy=0, load_ready=1 asynchronously; no flag after release.
- Program run: load MOV(0x45,re=1,n=15), STR(0x4A,1,0), LDR(0x49,2,0); pulse start -> opcode 0x45 for 2 cycles, 0x4A for 3, 0x49 for 3 (re=2, n=0), then flag=done=1 for 1 cycle, issue_cnt=3, err=0.
- Illegal and multi-cycle: load 0x00, then MUL(0x48,3,7); start -> one cycle of opcode 0, err=1, then 0x48 held 4 cycles, issue_cnt=1.
- Full buffer: push 16 entries -> load_ready=0; 17th push is ignored; run issues exactly 16.
- Abort: abort during the 2nd of 3 instructions -> next cycle IDLE, buffer empty, no flag, issue_cnt=2.
- Repeat: with HALL98_SEQ_REPEAT_EN, iters=3, program ADD(0x46,1,1) -> opcode 0x46 windows of 2 cycles, 3 back-to-back, then one flag, issue_cnt=3, buffer empty.
